// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port logic.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // Explicit encodings keep the state vector stable for anyone probing it.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index width for a requester count; never zero so NUM_REQ=1 still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping modulo NUM_REQ. Shared by write and read schedulers.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int cand;

  // Priority scan starting at the pointer; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default up front so no path through the loop
    // leaves one unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: runs a 32-entry init sweep after reset
// or on request, then shares the port round-robin among NUM_REQ requesters.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int                    NUM_REQ    = 3,
  parameter logic [REG_DATA_W-1:0] INIT_VALUE = 32'h0,
  parameter bit                    SKIP_X0    = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             init_req,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0]    req_reg,
  input  logic [REG_DATA_W*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             regwrite,
  output logic [REG_ADDR_W-1:0]            write_reg,
  output logic [REG_DATA_W-1:0]            write_data,
  output logic                             init_done
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e                 state_q, state_d;
  logic [REG_ADDR_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic                   regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0]  write_reg_q, write_reg_d;
  logic [REG_DATA_W-1:0]  write_data_q, write_data_d;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic [REG_ADDR_W-1:0]  sel_reg;
  logic [REG_DATA_W-1:0]  sel_data;
  logic                   in_run;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign in_run    = (state_q == ST_RUN);
  // Grants are only visible in RUN; they never wait on the output registers.
  assign req_ready = in_run ? grant : '0;
  assign init_done = in_run;
  assign regwrite  = regwrite_q;
  assign write_reg = write_reg_q;
  assign write_data = write_data_q;

  // Mux out the granted requester's address and data.
  assign sel_reg  = req_reg[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data = req_data[int'(grant_idx)*REG_DATA_W +: REG_DATA_W];

  // Next-state: sweep writes in INIT, granted transfers in RUN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    case (state_q)
      ST_INIT: begin
        regwrite_d   = 1'b1;
        write_reg_d  = cnt_q;
        write_data_d = INIT_VALUE;
        cnt_d        = cnt_q + REG_ADDR_W'(1);
        if (cnt_q == REG_ADDR_W'(NUM_REGS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (grant_any) begin
          write_reg_d  = sel_reg;
          write_data_d = sel_data;
          // A write to x0 is still consumed so the requester is released.
          regwrite_d   = !(SKIP_X0 && (sel_reg == '0));
          rr_d         = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers; async reset drops any in-flight write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      rr_q         <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with NUM_REQ=3, INIT_VALUE=0, SKIP_X0=1.
module tb_regfile_write_arbiter;

  localparam int N = 3;

  logic            clock;
  logic            reset;
  logic            init_req;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_reg;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            regwrite;
  logic [4:0]      write_reg;
  logic [31:0]     write_data;
  logic            init_done;

  int errors = 0;
  int checks = 0;
  logic [31:0] rf [32];

  regfile_write_arbiter #(.NUM_REQ(N), .INIT_VALUE(32'h0), .SKIP_X0(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .init_req   (init_req),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .regwrite   (regwrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .init_done  (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full sweep check; optionally pulses init_req at iteration pulse_at.
  task automatic sweep(input int pulse_at);
    for (int i = 0; i < 32; i++) begin
      if (i == pulse_at) init_req = 1'b1;
      #1;
      check("sweep_ready", 32'(req_ready), 32'h0);
      tick();
      init_req = 1'b0;
      check("sweep_we", 32'(regwrite), 32'h1);
      check("sweep_reg", 32'(write_reg), 32'(i));
      check("sweep_data", write_data, 32'h0);
      check("sweep_done", 32'(init_done), (i == 31) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    init_req  = 1'b0;
    req_valid = 3'b111;
    req_reg   = '0;
    req_data  = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hX;
    #2;
    check("rst_we", 32'(regwrite), 32'h0);
    check("rst_reg", 32'(write_reg), 32'h0);
    check("rst_data", write_data, 32'h0);
    check("rst_done", 32'(init_done), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);

    // Initial sweep with all requesters pending: ready must stay low.
    @(negedge clock);
    reset = 1'b1;
    sweep(-1);

    // Round robin across three holders.
    req_reg  = {5'd7, 5'd6, 5'd5};
    req_data = {32'hA2, 32'hA1, 32'hA0};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'h1 << (k % 3));
      tick();
      check("rr_we", 32'(regwrite), 32'h1);
      check("rr_reg", 32'(write_reg), 32'd5 + 32'(k % 3));
      check("rr_data", write_data, 32'hA0 + 32'(k % 3));
    end
    req_valid = 3'b000;
    tick();
    check("idle_we", 32'(regwrite), 32'h0);
    check("idle_hold_reg", 32'(write_reg), 32'd7);
    check("idle_hold_data", write_data, 32'hA2);

    // Write to x0 is consumed but not issued.
    req_reg   = {5'd0, 5'd0, 5'd0};
    req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
    req_valid = 3'b010;
    #1;
    check("x0_ready", 32'(req_ready), 32'h2);
    tick();
    check("x0_we", 32'(regwrite), 32'h0);
    check("x0_reg", 32'(write_reg), 32'h0);
    check("x0_data", write_data, 32'hDEADBEEF);
    req_valid = 3'b000;

    // Move pointer back to 0 via a req2 transfer.
    req_reg   = {5'd3, 5'd0, 5'd0};
    req_data  = {32'h33, 32'h0, 32'h0};
    req_valid = 3'b100;
    #1;
    check("ptr_ready", 32'(req_ready), 32'h4);
    tick();
    check("ptr_reg", 32'(write_reg), 32'd3);

    // Same-register collision: req0 then req2, later grant wins.
    req_reg   = {5'd9, 5'd0, 5'd9};
    req_data  = {32'h22, 32'h0, 32'h11};
    req_valid = 3'b101;
    #1;
    check("col_ready0", 32'(req_ready), 32'h1);
    tick();
    if (regwrite) rf[write_reg] = write_data;
    check("col_data0", write_data, 32'h11);
    req_valid = 3'b100;
    #1;
    check("col_ready2", 32'(req_ready), 32'h4);
    tick();
    if (regwrite) rf[write_reg] = write_data;
    check("col_data2", write_data, 32'h22);
    check("col_rf9", rf[9], 32'h22);

    // init_req in the same cycle as a grant: the transfer still lands.
    req_reg   = {5'd0, 5'd0, 5'd4};
    req_data  = {32'h0, 32'h0, 32'h55};
    req_valid = 3'b001;
    init_req  = 1'b1;
    #1;
    check("ireq_ready", 32'(req_ready), 32'h1);
    tick();
    init_req = 1'b0;
    check("ireq_we", 32'(regwrite), 32'h1);
    check("ireq_reg", 32'(write_reg), 32'd4);
    check("ireq_data", write_data, 32'h55);
    check("ireq_done", 32'(init_done), 32'h0);
    req_valid = 3'b111;
    sweep(10);   // init_req mid-sweep is ignored
    req_valid = 3'b000;

    // Reset mid-sweep at cnt=17.
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    check("re_init_we", 32'(regwrite), 32'h0);
    check("re_init_done", 32'(init_done), 32'h0);
    for (int i = 0; i < 17; i++) tick();
    check("mid_reg16", 32'(write_reg), 32'd16);
    #2;
    reset = 1'b0;
    #1;
    check("async_we", 32'(regwrite), 32'h0);
    check("async_reg", 32'(write_reg), 32'h0);
    check("async_data", write_data, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("restart_we", 32'(regwrite), 32'h1);
    check("restart_reg0", 32'(write_reg), 32'd0);
    tick();
    check("restart_reg1", 32'(write_reg), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file: regwrite, write_reg and write_data.
- Sequences an initialisation sweep of all 32 registers after reset or on request.
- Then shares the write port between NUM_REQ writeback requesters (e.g. ALU, load, bit-manip unit) using round-robin arbitration with valid/ready handshakes.
- Sits between the execute/writeback stages and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- INIT_VALUE, 32'h0, data written to every register during the init sweep.
- SKIP_X0, 1, when 1 an accepted write to register 0 is consumed but not issued.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init_req  in  1  one-cycle pulse; restarts the init sweep (honoured in RUN only).
- req_valid  in  NUM_REQ  requester i has a pending write.
- req_reg  in  5*NUM_REQ  destination register of requester i, at bits [5i+4:5i].
- req_data  in  32*NUM_REQ  write data of requester i, at bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant; a write transfers when valid&ready.
- regwrite  out  1  register file write enable.
- write_reg  out  5  register file write address.
- write_data  out  32  register file write data.
- init_done  out  1  high while in RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT, sweep counter=0, rr pointer=0.
  - regwrite=0, write_reg=0, write_data=0, init_done=0.
  - req_ready=0 (combinational, forced 0 outside RUN).
- FSM states: INIT, RUN.
- INIT:
  - Each cycle, register regwrite=1, write_reg=cnt, write_data=INIT_VALUE, then increment cnt.
  - The first write appears on the first clock edge after reset deasserts.
  - SKIP_X0 does not apply here: register 0 is written too.
  - After the edge that writes cnt=31: state=RUN, init_done=1, cnt wraps to 0.
  - The sweep is exactly 32 cycles with no gaps. req_ready is all zero throughout.
- RUN arbitration (combinational):
  - Scan req_valid starting at index rr, wrapping modulo NUM_REQ.
  - Grant the first valid index g: req_ready[g]=1, all others 0.
  - No valid requests: req_ready=0.
  - req_ready never depends on the output registers; it is not stalled.
- RUN transfer (registered, latency 1):
  - On the edge where valid&ready for g: write_reg=req_reg[g], write_data=req_data[g], rr=(g+1) mod NUM_REQ.
  - regwrite=1, except regwrite=0 when SKIP_X0=1 and req_reg[g]==0.
  - With no transfer: regwrite=0; write_reg/write_data hold their last values.
- Throughput: one write per cycle. A requester holding valid high is served at least once every NUM_REQ cycles.
- Requester rules:
  - A requester must hold valid, reg and data stable until ready is seen.
  - Dropping valid without a transfer is legal; the arbiter keeps no memory of it.
- Simultaneous requests to the same register: serialised in rr order, so the later grant wins in the register file.
- init_req in RUN:
  - On the next edge: state=INIT, cnt=0, init_done=0.
  - A transfer granted in that same cycle still completes (regwrite on that edge).
  - From the following cycle, req_ready=0.
  - init_req while in INIT is ignored; the sweep is not restarted.
- Reset mid-sweep or mid-transfer: everything returns to reset values immediately; any in-flight write is lost.
- NUM_REQ=1 degenerates to a pass-through with a register stage; rr stays 0.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - State enum {ST_INIT, ST_RUN}.
- Sub-module rr_arbiter (NUM_REQ param): inputs req, pointer; output one-hot grant and index. It is combinational and reusable for the future read-port scheduler.
- The FSM, sweep counter and output registers stay in regfile_write_arbiter.

Test Plan:
- Release reset, no requests → regwrite=1 for exactly 32 consecutive cycles with write_reg 0..31, write_data=0; init_done rises on cycle 33; req_ready stays 0 throughout.
- RUN, valid=3'b111 held, regs {5,6,7}, data {A0,A1,A2} → write_reg sequence 5,6,7,5,6,7…, one per cycle, each appearing the cycle after its ready.
- RUN, only req1 valid, reg 0, data 32'hDEADBEEF, SKIP_X0=1 → ready[1]=1 and the transfer completes, but regwrite=0 on the next cycle; write_reg=0 appears on the output.
- RUN, req0 and req2 both target reg 9 with 32'h11 and 32'h22, rr=0 → reg 9 written with 11 then 22 on consecutive cycles; a register file model reads 32'h22.
- init_req pulsed in the same cycle req0 is granted (reg 4, data 32'h55) → reg 4 written next cycle, then a full 32-cycle sweep; init_done low until it completes.
- Reset asserted mid-sweep at cnt=17 → outputs zero immediately (asynchronously); after release, the sweep restarts at write_reg=0.
